// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int LINE_W          = 128;

    function automatic int idx_w(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    // Word address = {tag, index, 2-bit word offset}.
    function automatic int tag_w(input int addr_w, input int num_blocks);
        return addr_w - 2 - $clog2(num_blocks);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits with synchronous clear, tags and 128-bit lines.
// Asynchronous read so hits resolve in the request cycle.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int TAG_W      = 25,
    parameter int IDX_W      = idx_w(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              word_en,
    input  logic [1:0]        word_sel,
    input  logic [31:0]       word_data
);

    logic [NUM_BLOCKS-1:0] valid_reg;
    logic [NUM_BLOCKS-1:0] dirty_reg;
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_en) begin
            valid_reg[wr_idx] <= 1'b1;
            dirty_reg[wr_idx] <= 1'b0;
        end else if (word_en) begin
            dirty_reg[wr_idx] <= 1'b1;
        end
    end

    // Tag/data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[wr_idx] <= fill_data;
            tag_mem[wr_idx]  <= fill_tag;
        end else if (word_en) begin
            data_mem[wr_idx][{word_sel, 5'b0} +: 32] <= word_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_dirty = dirty_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache: hit compare, miss FSM
// (IDLE/WRITEBACK/ALLOCATE) and registered memory-side request outputs.
module dcache
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 30
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic              proc_stall,
    output logic [31:0]       proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int IDX_W = idx_w(NUM_BLOCKS);
    localparam int TAG_W = tag_w(ADDR_W, NUM_BLOCKS);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              hit;
    logic              req;
    logic              idle;
    logic              fill_en;
    logic              word_en;

    state_t            state_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-3:0] mem_addr_reg;
    logic [LINE_W-1:0] mem_wdata_reg;

    assign req_off = proc_addr[OFF_W-1:0];
    assign req_idx = proc_addr[OFF_W +: IDX_W];
    assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];

    assign hit  = line_valid && (line_tag == req_tag);
    assign req  = proc_read || proc_write;
    assign idle = (state_reg == IDLE);

    assign proc_stall = !idle || (req && !hit);
    // Write wins when both requests are raised, so no read data is returned then.
    assign proc_rdata = (idle && proc_read && !proc_write && hit)
                      ? line_data[{req_off, 5'b0} +: 32] : 32'd0;

    assign fill_en = (state_reg == ALLOCATE) && mem_ready && !proc_reset;
    assign word_en = idle && proc_write && hit && !proc_reset;

    dcache_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk       (clk),
        .srst      (proc_reset),
        .rd_idx    (req_idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_idx    (req_idx),
        .fill_en   (fill_en),
        .fill_tag  (req_tag),
        .fill_data (mem_rdata),
        .word_en   (word_en),
        .word_sel  (req_off),
        .word_data (proc_wdata)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_reg     <= IDLE;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state_reg     <= WRITEBACK;
                            mem_write_reg <= 1'b1;
                            mem_addr_reg  <= {line_tag, req_idx};
                            mem_wdata_reg <= line_data;
                        end else begin
                            state_reg    <= ALLOCATE;
                            mem_read_reg <= 1'b1;
                            mem_addr_reg <= {req_tag, req_idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_reg     <= ALLOCATE;
                        mem_write_reg <= 1'b0;
                        mem_read_reg  <= 1'b1;
                        mem_addr_reg  <= {req_tag, req_idx};
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_reg    <= IDLE;
                        mem_read_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dcache.sv
// Directed testbench for dcache: acts as processor and as main memory,
// with hand-computed addresses and line contents.
module tb_dcache;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] LINE_A  = 128'hDDDD_CCCC_BBBB_AAAA_3333_2222_1111_0000;
    localparam logic [127:0] LINE_B  = 128'h4444_4444_3333_3333_2222_2222_0BAD_0030;
    localparam logic [127:0] LINE_C  = 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000;
    localparam logic [127:0] LINE_D  = 128'h5555_0003_5555_0002_5555_0001_5555_0000;
    localparam logic [127:0] VICT_A  = 128'hDDDD_CCCC_BBBB_AAAA_CAFE_F00D_1111_0000;
    localparam logic [127:0] VICT_C  = 128'hAAAA_0003_AAAA_0002_AAAA_0001_1234_5678;

    always #5 clk = ~clk;

    dcache #(.NUM_BLOCKS(8), .ADDR_W(30)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 ns after the edge, outputs settle 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [29:0] addr, input logic [31:0] wd);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        #1;
    endtask

    // Wait (bounded) for the request to appear; a miss must request in the very next cycle.
    task automatic wait_mem(input bit wb);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(wb ? mem_write : mem_read) && n < 20);
        check(wb ? "mem_write_seen" : "mem_read_seen", wb ? mem_write : mem_read, 1'b1);
        check("miss_latency", n, 1);
        #1;
    endtask

    // Hold the current request for r cycles, answer in cycle r, then expect it to drop.
    task automatic serve(input bit wb, input logic [27:0] exp_addr, input int r,
                         input logic [127:0] line, output logic [127:0] victim);
        victim = '0;
        for (int i = 1; i <= r; i++) begin
            check(wb ? "mem_write_held" : "mem_read_held", wb ? mem_write : mem_read, 1'b1);
            check(wb ? "mem_read_off" : "mem_write_off", wb ? mem_read : mem_write, 1'b0);
            check("mem_addr", mem_addr, exp_addr);
            check("stall_held", proc_stall, 1'b1);
            if (i == r) begin
                mem_ready = 1'b1;
                mem_rdata = line;
                victim    = mem_wdata;
            end
            step();
            mem_ready = 1'b0;
            #1;
        end
        check(wb ? "mem_write_drop" : "mem_read_drop", wb ? mem_write : mem_read, 1'b0);
    endtask

    initial begin
        logic [127:0] victim;

        proc_reset = 1'b1;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        drive(1'b0, 1'b0, 30'h0, 32'h0);
        step();
        step();
        proc_reset = 1'b0;
        step();
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, 28'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_stall", proc_stall, 1'b0);
        check("rst_rdata", proc_rdata, 32'h0);
        $display("reset: checks so far %0d", n_checks);

        // A stray mem_ready in IDLE must be ignored.
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        check("idle_ready_read", mem_read, 1'b0);
        check("idle_ready_write", mem_write, 1'b0);
        $display("idle mem_ready ignored");

        // Cold read miss at 0x10 -> block 0x4, answered 3 cycles after mem_read rises.
        drive(1'b1, 1'b0, 30'h10, 32'h0);
        check("cold_stall", proc_stall, 1'b1);
        wait_mem(1'b0);
        serve(1'b0, 28'h4, 3, LINE_A, victim);
        check("cold_stall_done", proc_stall, 1'b0);
        check("cold_rdata", proc_rdata, 32'h1111_0000);
        $display("cold read miss 0x10: rdata 0x%0h", proc_rdata);

        step();
        drive(1'b1, 1'b0, 30'h13, 32'h0);
        check("hit_stall", proc_stall, 1'b0);
        check("hit_rdata_w3", proc_rdata, 32'hDDDD_CCCC);
        $display("read hit 0x13: rdata 0x%0h", proc_rdata);

        // Write hit makes line 4 dirty.
        step();
        drive(1'b0, 1'b1, 30'h11, 32'hCAFE_F00D);
        check("wr_hit_stall", proc_stall, 1'b0);
        check("wr_hit_rdata0", proc_rdata, 32'h0);
        step();
        drive(1'b1, 1'b0, 30'h11, 32'h0);
        check("wr_hit_readback", proc_rdata, 32'hCAFE_F00D);
        $display("write hit 0x11: readback 0x%0h", proc_rdata);

        // Conflict on index 4 with tag 1: writeback of the dirty line, then refill from 0xC.
        step();
        drive(1'b1, 1'b0, 30'h30, 32'h0);
        check("conf_stall", proc_stall, 1'b1);
        wait_mem(1'b1);
        serve(1'b1, 28'h4, 2, 128'h0, victim);
        check("conf_victim_w1", victim[63:32], 32'hCAFE_F00D);
        check("conf_victim", victim, VICT_A);
        serve(1'b0, 28'hC, 1, LINE_B, victim);
        check("conf_stall_done", proc_stall, 1'b0);
        check("conf_rdata", proc_rdata, 32'h0BAD_0030);
        $display("dirty conflict 0x30: rdata 0x%0h", proc_rdata);

        // Write miss on clean (invalid) line 0: refill from 0x10, then the write hits.
        step();
        drive(1'b0, 1'b1, 30'h40, 32'h1234_5678);
        check("wmiss_stall", proc_stall, 1'b1);
        wait_mem(1'b0);
        serve(1'b0, 28'h10, 2, LINE_C, victim);
        check("wmiss_stall_done", proc_stall, 1'b0);
        step();
        drive(1'b1, 1'b0, 30'h40, 32'h0);
        check("wmiss_readback", proc_rdata, 32'h1234_5678);
        check("wmiss_readback_stall", proc_stall, 1'b0);
        $display("write miss 0x40: readback 0x%0h", proc_rdata);

        // Evict line 0 (tag 3) with a slow 10-cycle refill.
        step();
        drive(1'b1, 1'b0, 30'h60, 32'h0);
        wait_mem(1'b1);
        serve(1'b1, 28'h10, 1, 128'h0, victim);
        check("evict_victim", victim, VICT_C);
        serve(1'b0, 28'h18, 10, LINE_D, victim);
        check("slow_rdata", proc_rdata, 32'h5555_0000);
        check("slow_stall_done", proc_stall, 1'b0);
        $display("eviction + slow refill 0x60: rdata 0x%0h", proc_rdata);

        // Reset coincident with mem_ready during ALLOCATE: nothing installed.
        step();
        drive(1'b1, 1'b0, 30'h10, 32'h0);
        wait_mem(1'b0);
        check("rstmid_addr", mem_addr, 28'h4);
        mem_ready  = 1'b1;
        mem_rdata  = LINE_A;
        proc_reset = 1'b1;
        step();
        mem_ready  = 1'b0;
        proc_reset = 1'b0;
        #1;
        check("rstmid_mem_read", mem_read, 1'b0);
        check("rstmid_mem_write", mem_write, 1'b0);
        check("rstmid_stall_miss", proc_stall, 1'b1);
        check("rstmid_rdata", proc_rdata, 32'h0);
        wait_mem(1'b0);
        serve(1'b0, 28'h4, 1, LINE_A, victim);
        check("rstmid_refill_rdata", proc_rdata, 32'h1111_0000);
        $display("reset mid-allocate: re-read 0x10 rdata 0x%0h", proc_rdata);

        // 0x60 line was wiped by reset too: must miss cleanly (no writeback).
        step();
        drive(1'b1, 1'b0, 30'h60, 32'h0);
        check("rst_inval_stall", proc_stall, 1'b1);
        wait_mem(1'b0);
        serve(1'b0, 28'h18, 1, LINE_D, victim);
        check("rst_inval_rdata", proc_rdata, 32'h5555_0000);
        $display("post-reset miss 0x60: rdata 0x%0h", proc_rdata);

        drive(1'b0, 1'b0, 30'h0, 32'h0);
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache that sits between the MEM pipeline stage and main memory. It is the producer of the data-cache stall signal consumed by the pipeline stall controller. It answers hits combinationally in the same cycle. On a miss it raises `proc_stall` and runs a writeback/refill handshake with memory until the access can complete as a hit.

## Interface
- `NUM_BLOCKS`, 8: number of cache lines; power of two, ≥2.
- `ADDR_W`, 30: processor word-address width.
- `clk` in 1: single clock, rising edge.
- `proc_reset` in 1: synchronous, active-high reset.
- `proc_read` in 1: load request from MEM stage.
- `proc_write` in 1: store request from MEM stage.
- `proc_addr` in ADDR_W: word address.
- `proc_wdata` in 32: store data.
- `proc_stall` out 1: freeze the pipeline; feeds the stall controller's dcache stall input.
- `proc_rdata` out 32: load data; valid when a read is present and `proc_stall`=0.
- `mem_read` out 1: refill request.
- `mem_write` out 1: writeback request.
- `mem_addr` out ADDR_W-2: block address.
- `mem_wdata` out 128: victim line.
- `mem_rdata` in 128: refill line.
- `mem_ready` in 1: one-cycle completion pulse for the outstanding request.

## Operation
- Address split: offset = `proc_addr[1:0]`; index = next log2(NUM_BLOCKS) bits; tag = remaining upper bits. Each line holds 4 words, word k = bits [32k+31:32k].
- Per-line state: valid, dirty, tag, 128-bit data.
- `proc_write` has priority if both requests are asserted. The requester holds addr and wdata stable while `proc_stall`=1.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: `proc_stall`=0.
- IDLE, hit (valid and tag match):
  - `proc_stall`=0.
  - Read: `proc_rdata` = selected word, combinational.
  - Write: the word is updated at the clock edge and dirty is set.
- IDLE, miss, victim valid and dirty:
  - `proc_stall`=1.
  - Next state is WRITEBACK with `mem_write`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim line.
- IDLE, miss, victim clean or invalid:
  - `proc_stall`=1.
  - Next state is ALLOCATE with `mem_read`=1, `mem_addr`={req tag, index}.
- WRITEBACK:
  - `proc_stall`=1.
  - On `mem_ready`: `mem_write`←0, `mem_read`←1, `mem_addr`←{req tag, index}, go to ALLOCATE.
- ALLOCATE:
  - `proc_stall`=1.
  - On `mem_ready`: line←`mem_rdata`, valid←1, dirty←0, tag←req tag; `mem_read`←0; go to IDLE.
- A write miss is not merged during refill. After the return to IDLE the held request hits and the write completes as a normal write hit.
- `proc_rdata` when no read hit: 0.

## Timing
- Reset values: state IDLE; every line valid=0 and dirty=0; `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0. `proc_stall` follows IDLE rules, so it is 0 with no request.
- `mem_*` outputs are registered. `proc_stall` and `proc_rdata` are combinational from state, request and array.
- Hit latency: 0 cycles.
- Clean miss (miss in cycle 0, `mem_ready` at cycle r):
  - `mem_read` is high over cycles 1..r.
  - IDLE in cycle r+1; the hit completes in r+1 with `proc_stall`=0.
- Dirty miss adds the writeback phase: `mem_write` high until its `mem_ready`, then `mem_read` high from the next cycle.
- `mem_read` and `mem_write` are never high together. Each is held stable until `mem_ready`, then drops on the next edge.
- `mem_ready` is ignored in IDLE.
- Reset in any state, including mid-handshake:
  - Next cycle: IDLE, all lines invalid, `mem_read`=`mem_write`=0.
  - The in-flight memory transfer is abandoned.
  - Reset overrides a simultaneous `mem_ready`, so no line is installed.
- The request disappearing mid-miss is illegal. The block still finishes its current phase and returns to IDLE.

## Structure
- `dcache_pkg`: state encoding (IDLE/WRITEBACK/ALLOCATE), `WORDS_PER_BLOCK`=4, `LINE_W`=128, derived `IDX_W`/`TAG_W` functions.
- Sub-module `dcache_array`: valid/dirty/tag/data storage with a synchronous-reset valid/dirty clear, one read port (indexed) and one write port (whole-line fill or single-word write with dirty set).
- Top `dcache`: address split, hit compare, FSM, memory-side registers.

## Test plan
- Cold read miss:
  - Stimulus: after reset, read 0x10; `mem_ready` pulsed 3 cycles after `mem_read` rises, with `mem_rdata`=0xDDDD_CCCC_BBBB_AAAA_..., word0=0x1111_0000.
  - Required: `mem_addr`=0x4; `mem_read` high exactly 3 cycles; the next cycle has `proc_stall`=0 and `proc_rdata`=0x1111_0000.
- Read hit, other offset of the same line:
  - Stimulus: read 0x13.
  - Required: `proc_stall`=0 in the request cycle; `proc_rdata` = word3 of the filled line.
- Dirty conflict:
  - Stimulus: write 0xCAFE_F00D to 0x11 (hit), then read 0x30 (same index 4, tag 1).
  - Required: `mem_write` first with `mem_addr`=0x4 and `mem_wdata` word1=0xCAFE_F00D; then `mem_read` with `mem_addr`=0xC; never both high.
- Write miss on a clean line:
  - Stimulus: write 0x1234_5678 to 0x40.
  - Required: refill from `mem_addr`=0x10, then a write hit; a later eviction writes back word0=0x1234_5678.
- Slow memory:
  - Stimulus: `mem_ready` delayed 10 cycles.
  - Required: `proc_stall`, `mem_read` and `mem_addr` held constant for all 10 cycles.
- Reset mid-ALLOCATE:
  - Stimulus: `proc_reset` asserted in the same cycle as `mem_ready`.
  - Required: next cycle `mem_read`=0 and state IDLE; re-reading 0x10 misses again.
